// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage : instruction fetch front-end.
//
// Issues one word-aligned instruction-memory request at a time. Each returned
// instruction is passed to the decode stage through a registered output
// stage. A one-entry buffer absorbs a response that arrives while decode is
// stalled. A flush redirects the PC. A request that is still outstanding when
// the flush arrives is allowed to finish, but its response is discarded.
//
// Ports
//   fs_clk, fs_rst        clock (rising edge), asynchronous active-low reset
//   fs_i_ce               fetch enable (low: no new requests)
//   fs_i_stall            decode not accepting; outputs hold
//   fs_i_flush/target     one-cycle redirect pulse and redirect PC
//   fs_o_imem_req/addr    memory request and word-aligned address
//   fs_i_imem_ack/data    one-cycle memory response and instruction
//   fs_o_instr/pc/valid   instruction, its address, and real-instruction flag
//   fs_o_misalign         one-cycle flag for a misaligned redirect target
//
// Configuration
//   FS_ALIGN_CHECK_EN     when defined, a redirect with target[1:0] != 0 pulses
//                         fs_o_misalign. When undefined, the low bits are
//                         cleared silently and fs_o_misalign is tied low.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                PWIDTH   = 32,
    parameter int                IWIDTH   = 32,
    parameter logic [PWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              fs_clk,
    input  logic              fs_rst,
    input  logic              fs_i_ce,
    input  logic              fs_i_stall,
    input  logic              fs_i_flush,
    input  logic [PWIDTH-1:0] fs_i_target,
    output logic              fs_o_imem_req,
    output logic [PWIDTH-1:0] fs_o_imem_addr,
    input  logic              fs_i_imem_ack,
    input  logic [IWIDTH-1:0] fs_i_imem_data,
    output logic [IWIDTH-1:0] fs_o_instr,
    output logic [PWIDTH-1:0] fs_o_pc,
    output logic              fs_o_valid,
    output logic              fs_o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [IWIDTH-1:0] NOP      = {IWIDTH{1'b0}};
    localparam logic [PWIDTH-1:0] PC_STEP  = PWIDTH'(3'd4);
    localparam logic [PWIDTH-1:0] ALN_MASK = ~(PWIDTH'(2'b11));

    state_t            r_state_r;
    state_t            w_next_state_s;
    logic [PWIDTH-1:0] r_pc_r;          // next PC to fetch (redirect lands here)
    logic [PWIDTH-1:0] r_addr_r;        // address of the request on the bus
    logic              r_kill_r;        // outstanding response must be dropped
    logic [IWIDTH-1:0] r_buf_instr_r;
    logic [PWIDTH-1:0] r_buf_pc_r;
    logic [IWIDTH-1:0] r_instr_r;
    logic [PWIDTH-1:0] r_opc_r;
    logic              r_valid_r;
    logic              w_req_s;
    logic              w_ack_s;
    logic              w_deliver_s;
    logic              w_capture_s;
    logic [PWIDTH-1:0] w_target_s;
    logic [PWIDTH-1:0] w_pc_inc_s;

    // The mask keeps every target bit in the expression while forcing word alignment.
    assign w_target_s  = fs_i_target & ALN_MASK;
    assign w_pc_inc_s  = r_pc_r + PC_STEP;
    // A response counts only while a request is actually outstanding.
    assign w_ack_s     = (r_state_r == S_FETCH) && fs_i_imem_ack;
    // The response is live: it is neither killed nor discarded by a same-cycle flush.
    assign w_deliver_s = w_ack_s && !r_kill_r && !fs_i_flush;
    assign w_capture_s = w_deliver_s && fs_i_stall;

    // State register.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            r_state_r <= S_IDLE;
        end else begin
            r_state_r <= w_next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state_s = r_state_r;
        case (r_state_r)
            S_IDLE: begin
                if (fs_i_ce) begin
                    w_next_state_s = S_FETCH;
                end else begin
                    w_next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (!fs_i_imem_ack) begin
                    // Even a flush leaves the request pending until it completes.
                    w_next_state_s = S_FETCH;
                end else if (w_capture_s) begin
                    w_next_state_s = S_HOLD;
                end else if (fs_i_ce) begin
                    w_next_state_s = S_FETCH;
                end else begin
                    w_next_state_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (fs_i_flush || !fs_i_stall) begin
                    w_next_state_s = fs_i_ce ? S_FETCH : S_IDLE;
                end else begin
                    w_next_state_s = S_HOLD;
                end
            end
            default: begin
                w_next_state_s = S_IDLE;
            end
        endcase
    end

    // Output decode: a request is on the bus exactly while in FETCH.
    always_comb begin
        w_req_s = 1'b0;
        case (r_state_r)
            S_FETCH: w_req_s = 1'b1;
            default: w_req_s = 1'b0;
        endcase
    end

    assign fs_o_imem_req  = w_req_s;
    assign fs_o_imem_addr = r_addr_r;

    // PC, bus address, and kill flag. r_addr_r differs from r_pc_r only while
    // a killed request is still outstanding.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            r_pc_r   <= RESET_PC;
            r_addr_r <= RESET_PC;
            r_kill_r <= 1'b0;
        end else if (fs_i_flush) begin
            r_pc_r <= w_target_s;
            if ((r_state_r == S_FETCH) && !fs_i_imem_ack) begin
                r_addr_r <= r_addr_r;
                r_kill_r <= 1'b1;
            end else begin
                r_addr_r <= w_target_s;
                r_kill_r <= 1'b0;
            end
        end else if (w_ack_s) begin
            if (r_kill_r) begin
                r_pc_r   <= r_pc_r;
                r_addr_r <= r_pc_r;
            end else begin
                r_pc_r   <= w_pc_inc_s;
                r_addr_r <= w_pc_inc_s;
            end
            r_kill_r <= 1'b0;
        end else begin
            r_pc_r   <= r_pc_r;
            r_addr_r <= r_addr_r;
            r_kill_r <= r_kill_r;
        end
    end

    // One-entry skid buffer for a response that arrives during a stall.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            r_buf_instr_r <= NOP;
            r_buf_pc_r    <= {PWIDTH{1'b0}};
        end else if (w_capture_s) begin
            r_buf_instr_r <= fs_i_imem_data;
            r_buf_pc_r    <= r_addr_r;
        end else begin
            r_buf_instr_r <= r_buf_instr_r;
            r_buf_pc_r    <= r_buf_pc_r;
        end
    end

    // Decode-facing output register. Flush overrides stall; the buffer drains first.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            r_instr_r <= NOP;
            r_opc_r   <= {PWIDTH{1'b0}};
            r_valid_r <= 1'b0;
        end else if (fs_i_flush) begin
            r_instr_r <= NOP;
            r_opc_r   <= r_opc_r;
            r_valid_r <= 1'b0;
        end else if (fs_i_stall) begin
            r_instr_r <= r_instr_r;
            r_opc_r   <= r_opc_r;
            r_valid_r <= r_valid_r;
        end else if (w_deliver_s) begin
            r_instr_r <= fs_i_imem_data;
            r_opc_r   <= r_addr_r;
            r_valid_r <= 1'b1;
        end else if (r_state_r == S_HOLD) begin
            r_instr_r <= r_buf_instr_r;
            r_opc_r   <= r_buf_pc_r;
            r_valid_r <= 1'b1;
        end else begin
            r_instr_r <= NOP;
            r_opc_r   <= r_opc_r;
            r_valid_r <= 1'b0;
        end
    end

    assign fs_o_instr = r_instr_r;
    assign fs_o_pc    = r_opc_r;
    assign fs_o_valid = r_valid_r;

`ifdef FS_ALIGN_CHECK_EN
    logic r_misalign_r;

    // Pulse for one cycle after a redirect whose target is not word aligned.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            r_misalign_r <= 1'b0;
        end else begin
            r_misalign_r <= fs_i_flush && (fs_i_target[1:0] != 2'b00);
        end
    end

    assign fs_o_misalign = r_misalign_r;
`else
    assign fs_o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage : directed self-checking bench for fetch_stage.
// Inputs change 1 ns after each rising edge. Outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        fs_clk = 1'b0;
    logic        fs_rst;
    logic        fs_i_ce;
    logic        fs_i_stall;
    logic        fs_i_flush;
    logic [31:0] fs_i_target;
    logic        fs_o_imem_req;
    logic [31:0] fs_o_imem_addr;
    logic        fs_i_imem_ack;
    logic [31:0] fs_i_imem_data;
    logic [31:0] fs_o_instr;
    logic [31:0] fs_o_pc;
    logic        fs_o_valid;
    logic        fs_o_misalign;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_mis_s;

    fetch_stage #(
        .PWIDTH  (32),
        .IWIDTH  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .fs_clk        (fs_clk),
        .fs_rst        (fs_rst),
        .fs_i_ce       (fs_i_ce),
        .fs_i_stall    (fs_i_stall),
        .fs_i_flush    (fs_i_flush),
        .fs_i_target   (fs_i_target),
        .fs_o_imem_req (fs_o_imem_req),
        .fs_o_imem_addr(fs_o_imem_addr),
        .fs_i_imem_ack (fs_i_imem_ack),
        .fs_i_imem_data(fs_i_imem_data),
        .fs_o_instr    (fs_o_instr),
        .fs_o_pc       (fs_o_pc),
        .fs_o_valid    (fs_o_valid),
        .fs_o_misalign (fs_o_misalign)
    );

    // 100 MHz clock.
    always #5 fs_clk = ~fs_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fs_clk);
        #1;
    endtask

    // Drive a one-cycle memory response, optionally with stall and flush.
    task automatic ack_cycle(input logic [31:0] data, input logic stall,
                             input logic flush, input logic [31:0] tgt);
        fs_i_imem_ack  = 1'b1;
        fs_i_imem_data = data;
        fs_i_stall     = stall;
        fs_i_flush     = flush;
        fs_i_target    = tgt;
        tick();
        fs_i_imem_ack  = 1'b0;
        fs_i_imem_data = 32'h0000_0000;
        fs_i_flush     = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic valid);
        check_eq({tag, ".instr"}, fs_o_instr, instr);
        check_eq({tag, ".pc"}, fs_o_pc, pc);
        check_eq({tag, ".valid"}, {31'd0, fs_o_valid}, {31'd0, valid});
    endtask

    task automatic check_bus(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, ".req"}, {31'd0, fs_o_imem_req}, {31'd0, req});
        check_eq({tag, ".addr"}, fs_o_imem_addr, addr);
    endtask

    initial begin
`ifdef FS_ALIGN_CHECK_EN
        exp_mis_s = 1'b1;
`else
        exp_mis_s = 1'b0;
`endif
        fs_rst = 1'b0; fs_i_ce = 1'b1; fs_i_stall = 1'b0; fs_i_flush = 1'b0;
        fs_i_target = 32'h0000_0000; fs_i_imem_ack = 1'b0; fs_i_imem_data = 32'h0000_0000;
        #1;
        check_bus("rst", 1'b0, 32'h0000_0000);
        check_out("rst", 32'h0000_0000, 32'h0000_0000, 1'b0);
        check_eq("rst.mis", {31'd0, fs_o_misalign}, 32'd0);
        tick(); tick();
        fs_rst = 1'b1;

        // Basic fetch of two instructions.
        tick();
        check_bus("f0", 1'b1, 32'h0000_0000);
        tick();
        check_bus("f0hold", 1'b1, 32'h0000_0000);
        ack_cycle(32'h0043_0820, 1'b0, 1'b0, 32'h0);
        check_out("i0", 32'h0043_0820, 32'h0000_0000, 1'b1);
        check_bus("f1", 1'b1, 32'h0000_0004);
        tick();
        check_out("gap", 32'h0000_0000, 32'h0000_0000, 1'b0);
        ack_cycle(32'h00A6_2021, 1'b0, 1'b0, 32'h0);
        check_out("i1", 32'h00A6_2021, 32'h0000_0004, 1'b1);
        check_bus("f2", 1'b1, 32'h0000_0008);

        // Ack during stall goes to the buffer; outputs hold.
        ack_cycle(32'h0109_3822, 1'b1, 1'b0, 32'h0);
        check_out("stall0", 32'h00A6_2021, 32'h0000_0004, 1'b1);
        check_bus("hold", 1'b0, 32'h0000_000C);
        tick();
        check_out("stall1", 32'h00A6_2021, 32'h0000_0004, 1'b1);
        fs_i_stall = 1'b0;
        tick();
        check_out("drain", 32'h0109_3822, 32'h0000_0008, 1'b1);
        check_bus("f3", 1'b1, 32'h0000_000C);

        // Flush while the request at 12 is outstanding: it completes and is dropped.
        fs_i_flush = 1'b1; fs_i_target = 32'h0000_0040;
        tick();
        fs_i_flush = 1'b0;
        check_out("flush", 32'h0000_0000, 32'h0000_0008, 1'b0);
        check_bus("killreq", 1'b1, 32'h0000_000C);
        ack_cycle(32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check_eq("killed.valid", {31'd0, fs_o_valid}, 32'd0);
        check_bus("redir", 1'b1, 32'h0000_0040);
        ack_cycle(32'h1111_1111, 1'b0, 1'b0, 32'h0);
        check_out("t40", 32'h1111_1111, 32'h0000_0040, 1'b1);
        check_bus("f44", 1'b1, 32'h0000_0044);

        // Flush to a misaligned target in the same cycle as an ack.
        ack_cycle(32'h2222_2222, 1'b0, 1'b1, 32'h0000_0042);
        check_eq("ackflush.valid", {31'd0, fs_o_valid}, 32'd0);
        check_bus("aln", 1'b1, 32'h0000_0040);
        check_eq("mis1", {31'd0, fs_o_misalign}, {31'd0, exp_mis_s});
        tick();
        check_eq("mis0", {31'd0, fs_o_misalign}, 32'd0);

        // ce drops while a request is outstanding: it completes, then IDLE.
        fs_i_ce = 1'b0;
        tick();
        check_bus("ceoff", 1'b1, 32'h0000_0040);
        ack_cycle(32'h3333_3333, 1'b0, 1'b0, 32'h0);
        check_out("celast", 32'h3333_3333, 32'h0000_0040, 1'b1);
        check_bus("idle", 1'b0, 32'h0000_0044);

        // Asynchronous reset between edges.
        fs_i_ce = 1'b1;
        tick();
        ack_cycle(32'h4444_4444, 1'b0, 1'b0, 32'h0);
        check_out("prerst", 32'h4444_4444, 32'h0000_0044, 1'b1);
        #2 fs_rst = 1'b0;
        #1;
        check_bus("arst", 1'b0, 32'h0000_0000);
        check_out("arst", 32'h0000_0000, 32'h0000_0000, 1'b0);
        fs_i_ce = 1'b0;
        tick();
        fs_rst = 1'b1;
        // A stray ack with no request must be ignored.
        ack_cycle(32'h5555_5555, 1'b0, 1'b0, 32'h0);
        check_bus("stray", 1'b0, 32'h0000_0000);
        check_eq("stray.valid", {31'd0, fs_o_valid}, 32'd0);
        fs_i_ce = 1'b1;
        tick();
        check_bus("restart", 1'b1, 32'h0000_0000);

        // Redirect to the top word, then wrap to 0.
        fs_i_flush = 1'b1; fs_i_target = 32'hFFFF_FFFC;
        tick();
        fs_i_flush = 1'b0;
        ack_cycle(32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0);
        check_bus("top", 1'b1, 32'hFFFF_FFFC);
        ack_cycle(32'h6666_6666, 1'b0, 1'b0, 32'h0);
        check_out("topi", 32'h6666_6666, 32'hFFFF_FFFC, 1'b1);
        check_bus("wrap", 1'b1, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PWIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter IWIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 fs_clk  in  1  single clock, all state on rising edge.
REQ-005 fs_rst  in  1  reset, asynchronous, active-low.
REQ-006 fs_i_ce  in  1  fetch enable; low = issue no new requests.
REQ-007 fs_i_stall  in  1  decoder not accepting; outputs hold.
REQ-008 fs_i_flush  in  1  redirect request, one-cycle pulse.
REQ-009 fs_i_target  in  PWIDTH  redirect PC, sampled when fs_i_flush=1.
REQ-010 fs_o_imem_req  out  1  instruction memory request.
REQ-011 fs_o_imem_addr  out  PWIDTH  request address, word aligned.
REQ-012 fs_i_imem_ack  in  1  memory response valid, one cycle.
REQ-013 fs_i_imem_data  in  IWIDTH  response instruction.
REQ-014 fs_o_instr  out  IWIDTH  instruction to decode stage (drives ds_i_instr).
REQ-015 fs_o_pc  out  PWIDTH  address of fs_o_instr.
REQ-016 fs_o_valid  out  1  fs_o_instr holds a real instruction.
REQ-017 fs_o_misalign  out  1  misaligned redirect flag (see Configuration).

Function
REQ-018 SHALL have FSM states IDLE, FETCH, HOLD; at most one request outstanding.
REQ-019 IDLE: req=0; -> FETCH when fs_i_ce=1.
REQ-020 FETCH: req=1, addr=PC; req and addr SHALL stay stable until ack.
REQ-021 FETCH, ack=1, stall=0: next edge fs_o_instr=data, fs_o_pc=PC, fs_o_valid=1, PC+=4 (mod 2^PWIDTH); stay FETCH if ce=1, else IDLE.
REQ-022 FETCH, ack=1, stall=1: data/PC captured in 1-entry buffer, PC+=4, -> HOLD; outputs unchanged.
REQ-023 HOLD: req=0; when stall=0, buffer moves to outputs on next edge, -> FETCH (ce=1) or IDLE (ce=0).
REQ-024 Cycles with stall=1 SHALL leave fs_o_instr, fs_o_pc, fs_o_valid unchanged.
REQ-025 Cycle with stall=0 and no instruction delivered SHALL set fs_o_valid=0, fs_o_instr=32'h0000_0000 (NOP).
REQ-026 Latency: ack in cycle N -> fs_o_valid=1 after edge ending cycle N (1 cycle, registered).
REQ-027 Flush (priority over all): next edge PC=target, buffer emptied, fs_o_valid=0, fs_o_instr=NOP regardless of stall, state -> FETCH (ce=1) or IDLE.
REQ-028 Flush while request outstanding: request SHALL complete; its ack SHALL be discarded (kill flag), then new request at target.
REQ-029 Flush and ack same cycle: ack discarded, PC=target.
REQ-030 ce falling while request outstanding: request completes normally, then IDLE.
REQ-031 PC wrap: 32'hFFFF_FFFC + 4 SHALL give 32'h0000_0000 with no flag.

Reset
REQ-032 fs_rst=0 SHALL immediately force: PC=RESET_PC, state IDLE, req=0, addr=RESET_PC, fs_o_instr=0, fs_o_pc=0, fs_o_valid=0, fs_o_misalign=0, buffer empty, kill flag clear.
REQ-033 Reset mid-request SHALL abandon it; an ack arriving after reset release with no request issued SHALL be ignored.

Configuration
REQ-034 Macro FS_ALIGN_CHECK_EN defined: flush with fs_i_target[1:0]!=0 SHALL pulse fs_o_misalign=1 for one cycle after the edge and use target with [1:0] cleared.
REQ-035 Macro undefined: target[1:0] silently cleared, fs_o_misalign tied 0.

Verification
REQ-036 Reset 2 cycles, ce=1, memory acks 1 cycle after req with 32'h00430820, 32'h00A62021 -> fs_o_pc 0 then 4, fs_o_valid=1, addr 0,4,8.
REQ-037 Stall=1 during ack of 32'h01093822 at PC 8 -> outputs hold previous instruction; after stall=0, next edge fs_o_instr=32'h01093822, fs_o_pc=8.
REQ-038 Flush target 32'h0000_0040 while request at 12 outstanding -> ack at 12 discarded, fs_o_valid=0, next addr 32'h40.
REQ-039 Flush target 32'h0000_0042 -> addr 32'h40; fs_o_misalign=1 one cycle with FS_ALIGN_CHECK_EN, 0 without.
REQ-040 Async reset asserted mid-FETCH between edges -> req=0, fs_o_valid=0 immediately; restart at RESET_PC; flush to 32'hFFFF_FFFC then ack -> next addr 32'h0.
